// File: rtl/gcd_uart_tx.sv
// FIFO-buffered UART transmitter: 8N1 frames by default; defining UART_TX_PARITY_EN
// inserts an even-parity bit before STOP (11-bit frames).
module gcd_uart_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic [DIV_W-1:0]              clk_div,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          tx_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_e;
`endif

  state_e           state_q, state_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;
  logic [DIV_W-1:0] cyc_q, cyc_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  logic push;
  logic pop;
  logic bit_end;

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    cyc_d   = cyc_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    pop     = 1'b0;
    push    = in_valid && in_ready;
    bit_end = (cyc_q == div_q);

    if (state_q != IDLE) begin
      cyc_d = bit_end ? '0 : cyc_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = shreg_q[0];
          shreg_d = {1'b0, shreg_q[7:1]};
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shreg_q[0];
            shreg_d = {1'b0, shreg_q[7:1]};
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // A queued byte overrides the hop to IDLE so back-to-back frames leave no gap.
    if ((state_q == IDLE || (state_q == STOP && bit_end)) && level_q != '0) begin
      pop     = 1'b1;
      state_d = START;
      tx_d    = 1'b0;
      cyc_d   = '0;
      div_d   = clk_div;
      shreg_d = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
      par_d   = ^mem_q[rd_ptr_q];
`endif
    end

    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + LW'(push) - LW'(pop);
    done_d   = (state_d == STOP) && (cyc_d == div_q);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
      cyc_q    <= '0;
      div_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
      cyc_q    <= cyc_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
      if (push) begin
        mem_q[wr_ptr_q] <= in_data;
      end
    end
  end

  assign tx         = tx_q;
  assign tx_done    = done_q;
  assign fifo_level = level_q;
  assign in_ready   = (level_q != LW'(FIFO_DEPTH));
  assign busy       = (state_q != IDLE) || (level_q != '0);

endmodule

// File: tb/tb_gcd_uart_tx.sv
// Self-checking bench for gcd_uart_tx: directed scenarios plus random byte streams
// compared cycle-by-cycle against an ideal line waveform built from the frame format.
module tb_gcd_uart_tx;

  typedef logic [7:0]  byte_q_t[$];
  typedef int unsigned int_q_t[$];

  logic        clk = 1'b0;
  logic        wb_rst_i;
  logic [15:0] clk_div;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        tx;
  logic        busy;
  logic [2:0]  fifo_level;
  logic        tx_done;

  int total = 0;
  int bad   = 0;

  // Per-cycle log of the line, captured on the falling edge.
  logic        mon_en = 1'b0;
  logic        mon_prev = 1'b0;
  logic        line_log[$];
  logic        done_log[$];
  logic        busy_log[$];
  int          max_level;
  int          rdy_err;

  always #5 clk = ~clk;

  gcd_uart_tx #(.FIFO_DEPTH(4), .DIV_W(16)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (wb_rst_i),
    .clk_div    (clk_div),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_level (fifo_level),
    .tx_done    (tx_done)
  );

  always @(negedge clk) begin
    if (mon_en && !mon_prev) begin
      line_log.delete();
      done_log.delete();
      busy_log.delete();
      max_level = 0;
      rdy_err   = 0;
    end
    if (mon_en) begin
      line_log.push_back(tx);
      done_log.push_back(tx_done);
      busy_log.push_back(busy);
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
      if (in_ready !== (fifo_level != 3'd4)) rdy_err++;
    end
    mon_prev = mon_en;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    wb_rst_i = 1'b1;
    in_valid = 1'b0;
    tick(1);
    wb_rst_i = 1'b0;
    check("rst_tx", tx, 1);
    check("rst_level", fifo_level, 0);
    check("rst_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", tx_done, 0);
  endtask

  // While stalled, garbage is offered; it must never reach the line.
  task automatic push_byte(input logic [7:0] b);
    int unsigned guard = 0;
    in_valid = 1'b1;
    while (!in_ready && guard < 2000) begin
      in_data = 8'($urandom());
      tick(1);
      guard++;
    end
    check("push_ready", in_ready, 1);
    in_data = b;
    tick(1);
  endtask

  task automatic send_bytes(input byte_q_t q);
    foreach (q[k]) push_byte(q[k]);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned budget);
    int unsigned n = 0;
    while (busy && n < budget) begin
      tick(1);
      n++;
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic start_mon();
    mon_en = 1'b1;
    tick(1);
  endtask

  task automatic stop_mon();
    tick(3);
    mon_en = 1'b0;
    tick(1);
  endtask

  // Ideal waveform: per byte a start 0, data LSB first, optional even parity, stop 1,
  // each held div+1 cycles; tx_done high only on the final cycle of each stop bit.
  task automatic check_stream(input string tag, input byte_q_t bytes, input int_q_t divs);
    logic exp_tx[$];
    logic exp_dn[$];
    int   st;
    int   n;
    int   mism;
    int   first_bad;
    foreach (bytes[k]) begin
      logic [10:0] fb;
      int unsigned nb;
      fb       = '1;
      fb[0]    = 1'b0;
      fb[8:1]  = bytes[k];
`ifdef UART_TX_PARITY_EN
      fb[9]    = ^bytes[k];
      nb       = 11;
`else
      nb       = 10;
`endif
      for (int unsigned b = 0; b < nb; b++) begin
        for (int unsigned c = 0; c <= divs[k]; c++) begin
          exp_tx.push_back(fb[b]);
          exp_dn.push_back((b == nb - 1) && (c == divs[k]));
        end
      end
    end
    st = -1;
    foreach (line_log[i]) if (st < 0 && line_log[i] == 1'b0) st = i;
    check({tag, "_found"}, (st >= 0), 1);
    if (st < 0) st = 0;
    n = exp_tx.size();
    check({tag, "_len"}, (line_log.size() > st + n), 1);
    mism = 0;
    first_bad = -1;
    for (int i = 0; i < line_log.size(); i++) begin
      logic et;
      logic ed;
      int   m0;
      m0 = mism;
      et = 1'b1;
      ed = 1'b0;
      if (i >= st && i < st + n) begin
        et = exp_tx[i - st];
        ed = exp_dn[i - st];
        if (busy_log[i] !== 1'b1) mism++;
      end
      if (i >= st + n && busy_log[i] !== 1'b0) mism++;
      if (line_log[i] !== et) mism++;
      if (done_log[i] !== ed) mism++;
      if (mism != m0 && first_bad < 0) first_bad = i - st;
    end
    check($sformatf("%s_line(first_bad_cycle=%0d)", tag, first_bad), mism, 0);
  endtask

  initial begin
    byte_q_t bq;
    int_q_t  dq;
    int      lows;
    int      dones;

    wb_rst_i = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    clk_div  = 16'd3;
    tick(2);
    do_reset();

    // Single 0x55 at 4 cycles/bit, with push-to-start latency checked directly.
    start_mon();
    in_valid = 1'b1;
    in_data  = 8'h55;
    tick(1);
    in_valid = 1'b0;
    check("f55_tx_after_push", tx, 1);
    check("f55_level_after_push", fifo_level, 1);
    check("f55_busy_after_push", busy, 1);
    tick(1);
    check("f55_tx_start", tx, 0);
    check("f55_level_popped", fifo_level, 0);
    wait_idle(200);
    stop_mon();
    bq = '{8'h55};
    dq = '{3};
    check_stream("f55", bq, dq);

    // Three back-to-back frames at one cycle per bit.
    clk_div = 16'd0;
    start_mon();
    bq = '{8'hA3, 8'h0F, 8'hFF};
    send_bytes(bq);
    wait_idle(200);
    stop_mon();
    dq = '{0, 0, 0};
    check_stream("b2b", bq, dq);

    // Six bytes with valid held: FIFO fills and backpressures.
    clk_div = 16'd1;
    start_mon();
    bq.delete();
    dq.delete();
    for (int k = 0; k < 6; k++) begin
      bq.push_back(8'($urandom()));
      dq.push_back(1);
    end
    send_bytes(bq);
    wait_idle(400);
    stop_mon();
    check_stream("full", bq, dq);
    check("full_max_level", max_level, 4);
    check("full_ready_rule", rdy_err, 0);

    // clk_div changes mid-frame: only the next frame picks it up.
    clk_div = 16'd3;
    start_mon();
    bq = '{8'h5A, 8'hC3};
    send_bytes(bq);
    tick(8);
    clk_div = 16'd9;
    wait_idle(400);
    stop_mon();
    dq = '{3, 9};
    check_stream("divchg", bq, dq);

`ifdef UART_TX_PARITY_EN
    clk_div = 16'd2;
    start_mon();
    bq = '{8'h07};
    send_bytes(bq);
    wait_idle(200);
    stop_mon();
    dq = '{2};
    check_stream("par07", bq, dq);
    start_mon();
    bq = '{8'h03};
    send_bytes(bq);
    wait_idle(200);
    stop_mon();
    check_stream("par03", bq, dq);
`endif

    // Random streams, random divisor.
    for (int r = 0; r < 4; r++) begin
      int unsigned dv;
      int unsigned nb;
      dv = $urandom_range(0, 4);
      nb = $urandom_range(1, 7);
      clk_div = 16'(dv);
      bq.delete();
      dq.delete();
      for (int unsigned k = 0; k < nb; k++) begin
        bq.push_back(8'($urandom()));
        dq.push_back(dv);
      end
      start_mon();
      send_bytes(bq);
      wait_idle(1000);
      stop_mon();
      check_stream($sformatf("rand%0d_div%0d", r, dv), bq, dq);
    end

    // Reset during data bit 3 with two bytes still queued.
    clk_div = 16'd7;
    bq = '{8'h11, 8'h22, 8'h33};
    send_bytes(bq);
    tick(33);
    check("midrst_level_before", fifo_level, 2);
    check("midrst_tx_low_bit3", tx, 0);
    wb_rst_i = 1'b1;
    tick(1);
    wb_rst_i = 1'b0;
    check("midrst_tx", tx, 1);
    check("midrst_level", fifo_level, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", in_ready, 1);
    lows  = 0;
    dones = 0;
    for (int k = 0; k < 200; k++) begin
      tick(1);
      if (tx == 1'b0) lows++;
      if (tx_done == 1'b1) dones++;
    end
    check("midrst_no_frames", lows, 0);
    check("midrst_no_done", dones, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
